v5_peak_detector: RTL
=====================

V5_PEAK_DETECTOR -- requirements
Module: v5_peak_detector

Interface
REQ-001 Parameter THRESHOLD, default 100: signed arm level, compared against filter_data.
REQ-002 Parameter HOLDOFF, default 4: dead-time cycles after each report; 0 is legal.
REQ-003 Parameter TS_WIDTH, default 32: timestamp counter width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 filter_data  input  SIZE_PEAK_DATA  signed trapezoid filter output, one sample per clk.
REQ-007 peak_value  output  SIZE_PEAK_DATA  signed maximum of the last pulse.
REQ-008 peak_time  output  TS_WIDTH  timestamp of that maximum.
REQ-009 peak_valid  output  1  result held for consumer.
REQ-010 peak_ready  input  1  consumer accepts the result when high with peak_valid.
REQ-011 overflow_cnt  output  16  saturating count of dropped peaks.

Function
REQ-012 filter_data shall be registered once (x_q) before any comparison.
REQ-013 The FSM shall have the states IDLE, ARMED, REPORT and HOLDOFF.
REQ-014 IDLE: if x_q > THRESHOLD, go to ARMED with max<=x_q and ts<=tcnt; otherwise stay.
REQ-015 ARMED: if x_q > max, update max and ts; equal values shall not update (first occurrence kept).
REQ-016 ARMED: if x_q <= THRESHOLD, go to REPORT.
REQ-017 REPORT shall last one cycle; if the output slot is free or consumed this cycle, load peak_value<=max and peak_time<=ts and set peak_valid; otherwise drop the peak and increment overflow_cnt (saturating at 0xFFFF).
REQ-018 REPORT shall go to HOLDOFF with a counter of HOLDOFF; when HOLDOFF=0 it shall go directly to IDLE.
REQ-019 HOLDOFF shall ignore x_q, decrement each cycle, and return to IDLE when the counter reaches 1.
REQ-020 Latency: peak_valid shall rise on the 3rd rising edge after the first sample <= THRESHOLD is presented.
REQ-021 Handshake: peak_valid and the outputs shall stay stable until peak_valid && peak_ready; peak_valid shall then clear on that edge unless a REPORT load coincides, in which case the load wins and peak_valid stays 1.
REQ-022 peak_ready shall have no effect while peak_valid is 0.
REQ-023 tcnt shall be free-running, increment every cycle and wrap modulo 2^TS_WIDTH.
REQ-024 Comparisons shall be full-width signed; max shall be SIZE_PEAK_DATA wide with no truncation.

Reset
REQ-025 Asserted reset shall immediately force: state IDLE, x_q, max, ts, tcnt, peak_value, peak_time, overflow_cnt = 0, and peak_valid = 0.
REQ-026 Reset mid-pulse or mid-handshake shall discard any pending peak; after release, detection shall restart from IDLE.

Configuration
REQ-027 Macro V5_PEAK_TIMESTAMP_EN controls the timestamp feature.
REQ-028 When the macro is defined, tcnt, ts and peak_time shall be implemented as specified above.
REQ-029 When the macro is undefined, there shall be no tcnt or ts registers, and peak_time shall be constant 0; all other behaviour shall be unchanged.

Structure
REQ-030 package_settings_v_5.sv shall define SIZE_PEAK_DATA = SIZE_FILTER_DATA+4.
REQ-031 package_settings_v_5.sv shall define typedef enum peak_state_v_5_t {IDLE, ARMED, REPORT, HOLDOFF}.
REQ-032 package_settings_v_5.sv shall define the default THRESHOLD_v_5 and HOLDOFF_v_5 values.
REQ-033 The timestamp counter shall be a sub-module named v5_timestamp_counter, instantiated only under V5_PEAK_TIMESTAMP_EN.
REQ-034 v5_peak_detector shall connect directly to v5_filter.output_data.

Verification
REQ-035 Single pulse: input 0,150,300,250,90,0 with peak_ready=1 -> one peak_valid pulse with peak_value=300 and peak_time = tcnt at the 300 sample; the latency check in REQ-020 shall hold.
REQ-036 Plateau: input 50,200,200,200,40 -> peak_value=200 and peak_time at the first 200.
REQ-037 Backpressure: peak_ready=0 across two pulses of maxima 300 and 400 -> outputs hold 300, overflow_cnt=1, and 300 is delivered once peak_ready rises.
REQ-038 Simultaneous accept and load: peak_ready pulses in the REPORT cycle of a second pulse -> peak_valid stays 1 and peak_value switches to the new maximum.
REQ-039 Holdoff and threshold: HOLDOFF=4 with a second pulse starting 2 cycles after REPORT -> the second pulse is ignored until HOLDOFF ends; input exactly 100 never arms.
REQ-040 Reset: assert reset while ARMED with max=250 -> all outputs read 0 immediately, and no peak is reported after release.

Source files
------------

// File: rtl/package_settings_v_5.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | package_settings_v_5                                                     |
// | Shared widths, default detector settings and FSM state type.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package package_settings_v_5;

    localparam int SIZE_FILTER_DATA = 16;
    // Headroom for the trapezoid filter's gain.
    localparam int SIZE_PEAK_DATA   = SIZE_FILTER_DATA + 4;

    localparam int THRESHOLD_v_5 = 100;
    localparam int HOLDOFF_v_5   = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        REPORT  = 2'd2,
        HOLDOFF = 2'd3
    } peak_state_v_5_t;

endpackage
`default_nettype wire

// File: rtl/v5_timestamp_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | v5_timestamp_counter                                                     |
// | Free-running, wrapping timestamp counter for the peak detector.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module v5_timestamp_counter #(
    parameter int TS_WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    output logic [TS_WIDTH-1:0] count_o
);

    logic [TS_WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + TS_WIDTH'(1);
        end
    end

    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/v5_peak_detector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | v5_peak_detector                                                         |
// | Pulse-maximum detector with hold-off and a valid/ready result slot.      |
// | Timestamps are built only when V5_PEAK_TIMESTAMP_EN is defined.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module v5_peak_detector #(
    parameter int THRESHOLD = package_settings_v_5::THRESHOLD_v_5,
    parameter int HOLDOFF   = package_settings_v_5::HOLDOFF_v_5,
    parameter int TS_WIDTH  = 32
) (
    input  logic                                                  clk,
    input  logic                                                  reset,
    input  logic signed [package_settings_v_5::SIZE_PEAK_DATA-1:0] filter_data,
    output logic signed [package_settings_v_5::SIZE_PEAK_DATA-1:0] peak_value,
    output logic        [TS_WIDTH-1:0]                            peak_time,
    output logic                                                  peak_valid,
    input  logic                                                  peak_ready,
    output logic        [15:0]                                    overflow_cnt
);

    // The HOLDOFF state is referenced through the package scope because the
    // parameter of the same name lives in this module.
    import package_settings_v_5::peak_state_v_5_t;
    import package_settings_v_5::IDLE;
    import package_settings_v_5::ARMED;
    import package_settings_v_5::REPORT;
    import package_settings_v_5::SIZE_PEAK_DATA;

    localparam int                           c_W      = SIZE_PEAK_DATA;
    localparam logic signed [c_W-1:0]        c_THRESH = c_W'(THRESHOLD);
    localparam int                           c_HW     = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic        [c_HW-1:0]       c_HOLD   = c_HW'(HOLDOFF);

    peak_state_v_5_t        state_q, state_d;
    logic signed [c_W-1:0]  x_q;
    logic signed [c_W-1:0]  max_q, max_d;
    logic signed [c_W-1:0]  value_q, value_d;
    logic        [c_HW-1:0] hold_q, hold_d;
    logic                   valid_q, valid_d;
    logic        [15:0]     ovf_q, ovf_d;
    logic                   w_capture;
    logic                   w_load;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            max_q   <= '0;
            hold_q  <= '0;
            value_q <= '0;
            valid_q <= 1'b0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= filter_data;
            max_q   <= max_d;
            hold_q  <= hold_d;
            value_q <= value_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        max_d     = max_q;
        hold_d    = hold_q;
        w_capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (x_q > c_THRESH) begin
                    state_d   = ARMED;
                    w_capture = 1'b1;
                end
            end
            ARMED: begin
                // Strict '>' keeps the first sample of a flat top.
                if (x_q <= c_THRESH) begin
                    state_d = REPORT;
                end else if (x_q > max_q) begin
                    w_capture = 1'b1;
                end
            end
            REPORT: begin
                if (HOLDOFF == 0) begin
                    state_d = IDLE;
                end else begin
                    state_d = package_settings_v_5::HOLDOFF;
                    hold_d  = c_HOLD;
                end
            end
            package_settings_v_5::HOLDOFF: begin
                if (hold_q <= c_HW'(1)) begin
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q - c_HW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (w_capture) begin
            max_d = x_q;
        end
    end

    // A fresh result may replace one that is being consumed on the same edge.
    assign w_load = (state_q == REPORT) && (!valid_q || peak_ready);

    always_comb begin
        value_d = value_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        if (w_load) begin
            value_d = max_q;
            valid_d = 1'b1;
        end else if (valid_q && peak_ready) begin
            valid_d = 1'b0;
        end
        if ((state_q == REPORT) && !w_load && (ovf_q != 16'hFFFF)) begin
            ovf_d = ovf_q + 16'd1;
        end
    end

`ifdef V5_PEAK_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] tcnt;
    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic [TS_WIDTH-1:0] time_q, time_d;

    v5_timestamp_counter #(
        .TS_WIDTH (TS_WIDTH)
    ) u_tcnt (
        .clk     (clk),
        .reset   (reset),
        .count_o (tcnt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_q   <= '0;
            time_q <= '0;
        end else begin
            ts_q   <= ts_d;
            time_q <= time_d;
        end
    end

    always_comb begin
        ts_d   = w_capture ? tcnt : ts_q;
        time_d = w_load ? ts_q : time_q;
    end

    assign peak_time = time_q;
`else
    assign peak_time = '0;
`endif

    assign peak_value   = value_q;
    assign peak_valid   = valid_q;
    assign overflow_cnt = ovf_q;

endmodule
`default_nettype wire
